// File: rtl/avalon_s_rr_arbiter.sv
// rtl/avalon_s_rr_arbiter.sv - round-robin arbiter sharing one Avalon-MM device among NH hosts
// Optional waitrequest timeout is built when AVN_ARB_TIMEOUT_EN is defined.
module avalon_s_rr_arbiter #(
   parameter int NH      = 2,
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NH-1:0]            hosts_avn_read,
   input  logic [NH-1:0]            hosts_avn_write,
   input  logic [NH-1:0][AW-1:0]    hosts_avn_address,
   input  logic [NH-1:0][DW/8-1:0]  hosts_avn_byte_enable,
   input  logic [NH-1:0][DW-1:0]    hosts_avn_writedata,
   output logic [NH-1:0][DW-1:0]    hosts_avn_readdata,
   output logic [NH-1:0]            hosts_avn_waitrequest,
   output logic                     device_avn_read,
   output logic                     device_avn_write,
   output logic [AW-1:0]            device_avn_address,
   output logic [DW/8-1:0]          device_avn_byte_enable,
   output logic [DW-1:0]            device_avn_writedata,
   input  logic [DW-1:0]            device_avn_readdata,
   input  logic                     device_avn_waitrequest
`ifdef AVN_ARB_TIMEOUT_EN
   ,
   output logic                     arb_timeout
`endif
);

   localparam int GW = $clog2(NH);
   localparam bit CFG_OK = (NH >= 2) && (NH <= 16) && (DW % 8 == 0) && (DW > 0)
                           && (TIMEOUT >= 2) && (TIMEOUT <= 65535);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t           state;
   logic [GW-1:0]    grant;
   logic [GW-1:0]    ptr;
   logic [GW-1:0]    winner;
   logic [NH-1:0]    req;
   logic             in_grant;
   logic             g_read;
   logic             g_write;
   logic             g_req;
   logic             tout;

   // Illegal parameter sets elaborate this named block so they stand out in the hierarchy.
   if (!CFG_OK) begin : g_illegal_config
      logic cfg_error;
      assign cfg_error = 1'b1;
   end

   assign req      = hosts_avn_read | hosts_avn_write;
   assign in_grant = (state == S_GRANT);
   assign g_read   = hosts_avn_read[grant];
   assign g_write  = hosts_avn_write[grant];
   assign g_req    = g_read | g_write;

   // First requester strictly after the last completed owner, wrapping around.
   always_comb begin
      logic found;
      winner = '0;
      found  = 1'b0;
      for (int k = 1; k <= NH; k++) begin
         int idx;
         idx = (int'(ptr) + k) % NH;
         if (!found && req[idx]) begin
            winner = GW'(idx);
            found  = 1'b1;
         end
      end
   end

   assign device_avn_read        = in_grant & ~tout & g_read;
   assign device_avn_write       = in_grant & ~tout & g_write;
   assign device_avn_address     = in_grant ? hosts_avn_address[grant]     : '0;
   assign device_avn_byte_enable = in_grant ? hosts_avn_byte_enable[grant] : '0;
   assign device_avn_writedata   = in_grant ? hosts_avn_writedata[grant]   : '0;

   always_comb begin
      hosts_avn_waitrequest = '1;
      if (in_grant)
         hosts_avn_waitrequest[grant] = tout ? 1'b0 : device_avn_waitrequest;
   end

   // Read data is broadcast; only the timed-out owner sees zeros.
   always_comb begin
      for (int i = 0; i < NH; i++)
         hosts_avn_readdata[i] = device_avn_readdata;
      if (tout)
         hosts_avn_readdata[grant] = '0;
   end

`ifdef AVN_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] stall_cnt;
   logic          stalled;

   assign tout    = arb_timeout;
   assign stalled = in_grant & ~tout & g_req & device_avn_waitrequest;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt   <= '0;
         arb_timeout <= 1'b0;
      end else begin
         arb_timeout <= 1'b0;
         if (stalled) begin
            stall_cnt <= stall_cnt + CW'(1);
            if (stall_cnt == CW'(TIMEOUT - 1))
               arb_timeout <= 1'b1;
         end else begin
            stall_cnt <= '0;
         end
      end
   end
`else
   assign tout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         grant <= '0;
         ptr   <= GW'(NH - 1);
      end else begin
         case (state)
            S_IDLE: begin
               if (|req) begin
                  grant <= winner;
                  state <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (tout) begin
                  state <= S_IDLE;
                  ptr   <= grant;
               end else if (!g_req) begin
                  // Abandoned request: no transfer happened, so the pointer keeps its place.
                  state <= S_IDLE;
               end else if (!device_avn_waitrequest) begin
                  state <= S_IDLE;
                  ptr   <= grant;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_s_rr_arbiter.sv
// tb/tb_avalon_s_rr_arbiter.sv - directed and random checks of avalon_s_rr_arbiter against a transaction model
module tb_avalon_s_rr_arbiter;

   localparam int NH = 3;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 4;

   logic                     clk;
   logic                     rst;
   logic [NH-1:0]            h_rd;
   logic [NH-1:0]            h_wr;
   logic [NH-1:0][AW-1:0]    h_addr;
   logic [NH-1:0][DW/8-1:0]  h_be;
   logic [NH-1:0][DW-1:0]    h_wd;
   logic [NH-1:0][DW-1:0]    h_rdata;
   logic [NH-1:0]            h_wait;
   logic                     d_rd;
   logic                     d_wr;
   logic [AW-1:0]            d_addr;
   logic [DW/8-1:0]          d_be;
   logic [DW-1:0]            d_wd;
   logic [DW-1:0]            d_rdata;
   logic                     d_wait;
`ifdef AVN_ARB_TIMEOUT_EN
   logic                     arb_to;
`endif

   int errors;
   int checks;

   // Transaction-level model: who owns the device, who completed last, stall count.
   bit m_busy;
   bit m_tout;
   int m_owner;
   int m_ptr;
   int m_cnt;

   avalon_s_rr_arbiter #(.NH(NH), .DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .hosts_avn_read         (h_rd),
      .hosts_avn_write        (h_wr),
      .hosts_avn_address      (h_addr),
      .hosts_avn_byte_enable  (h_be),
      .hosts_avn_writedata    (h_wd),
      .hosts_avn_readdata     (h_rdata),
      .hosts_avn_waitrequest  (h_wait),
      .device_avn_read        (d_rd),
      .device_avn_write       (d_wr),
      .device_avn_address     (d_addr),
      .device_avn_byte_enable (d_be),
      .device_avn_writedata   (d_wd),
      .device_avn_readdata    (d_rdata),
      .device_avn_waitrequest (d_wait)
`ifdef AVN_ARB_TIMEOUT_EN
      ,
      .arb_timeout            (arb_to)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic ck(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int rr_winner();
      for (int k = 1; k <= NH; k++) begin
         int idx = (m_ptr + k) % NH;
         if (h_rd[idx] | h_wr[idx]) return idx;
      end
      return 0;
   endfunction

   // Compare every output against the model, away from the rising edge.
   task automatic chk();
      logic                    e_rd, e_wr;
      logic [AW-1:0]           e_addr;
      logic [DW/8-1:0]         e_be;
      logic [DW-1:0]           e_wd;
      logic [NH-1:0]           e_wait;
      logic [NH-1:0][DW-1:0]   e_rdata;
      @(negedge clk);
      e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_be = '0; e_wd = '0; e_wait = '1;
      for (int i = 0; i < NH; i++) e_rdata[i] = d_rdata;
      if (m_busy) begin
         e_addr = h_addr[m_owner];
         e_be   = h_be[m_owner];
         e_wd   = h_wd[m_owner];
         if (m_tout) begin
            e_wait[m_owner]  = 1'b0;
            e_rdata[m_owner] = '0;
         end else begin
            e_rd = h_rd[m_owner];
            e_wr = h_wr[m_owner];
            e_wait[m_owner] = d_wait;
         end
      end
      ck("dev_read", d_rd, e_rd);
      ck("dev_write", d_wr, e_wr);
      ck("dev_addr", d_addr, e_addr);
      ck("dev_be", d_be, e_be);
      ck("dev_wdata", d_wd, e_wd);
      ck("host_wait", h_wait, e_wait);
      ck("host_rdata", h_rdata, e_rdata);
`ifdef AVN_ARB_TIMEOUT_EN
      ck("arb_timeout", arb_to, m_tout);
`endif
   endtask

   task automatic adv();
      @(posedge clk);
      if (rst) begin
         m_busy = 0; m_tout = 0; m_owner = 0; m_ptr = NH - 1; m_cnt = 0;
      end else if (!m_busy) begin
         if (|(h_rd | h_wr)) begin
            m_owner = rr_winner();
            m_busy  = 1;
         end
      end else if (m_tout) begin
         m_busy = 0; m_tout = 0; m_ptr = m_owner; m_cnt = 0;
      end else if (!(h_rd[m_owner] | h_wr[m_owner])) begin
         m_busy = 0; m_cnt = 0;
      end else if (!d_wait) begin
         m_busy = 0; m_ptr = m_owner; m_cnt = 0;
      end else begin
         m_cnt++;
`ifdef AVN_ARB_TIMEOUT_EN
         if (m_cnt == TO) m_tout = 1;
`endif
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; h_rd = '0; h_wr = '0;
      adv();
      rst = 1'b0;
   endtask

   logic [NH-1:0] r35_tbl [8];

   initial begin
      errors = 0; checks = 0;
      m_busy = 0; m_tout = 0; m_owner = 0; m_ptr = NH - 1; m_cnt = 0;
      rst = 1'b1; h_rd = 3'b011; h_wr = 3'b100; d_wait = 1'b0; d_rdata = 32'h1234_5678;
      for (int i = 0; i < NH; i++) begin
         h_addr[i] = 32'hA000_0000 + i; h_be[i] = 4'hF; h_wd[i] = 32'h5500_0000 + i;
      end

      // Reset with hosts active: idle outputs.
      adv();
      chk();
      ck("rst_wait_all", h_wait, 3'b111);
      ck("rst_dev_read", d_rd, 1'b0);
      ck("rst_dev_addr", d_addr, 32'h0);
      do_reset();

      // Host 0 read at 0x100, zero-wait device.
      h_rd = 3'b001; h_addr[0] = 32'h100; d_wait = 1'b0;
      chk(); ck("r34_c0_read", d_rd, 1'b0); adv();
      chk();
      ck("r34_c1_read", d_rd, 1'b1);
      ck("r34_c1_addr", d_addr, 32'h100);
      ck("r34_c1_wait0", h_wait[0], 1'b0);
      adv();
      h_rd = '0;
      chk(); ck("r34_c2_idle", h_wait, 3'b111); adv();

      // All hosts requesting continuously: 0,1,2,0 with idle gaps.
      r35_tbl = '{3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011, 3'b111, 3'b110};
      do_reset();
      h_rd = '1; d_wait = 1'b0;
      for (int c = 0; c < 8; c++) begin
         chk(); ck($sformatf("r35_wait_c%0d", c), h_wait, r35_tbl[c]); adv();
      end
      h_rd = '0;

      // Host 1 write held off by 3 stall cycles; host 0 arrives mid-grant.
      do_reset();
      h_wr = 3'b010; h_addr[1] = 32'h200; h_wd[1] = 32'hCAFE_F00D; h_be[1] = 4'hF; d_wait = 1'b1;
      chk(); adv();
      h_rd = 3'b001;
      for (int c = 0; c < 4; c++) begin
         d_wait = (c < 3);
         chk();
         ck($sformatf("r36_write_c%0d", c), d_wr, 1'b1);
         ck($sformatf("r36_wdata_c%0d", c), d_wd, 32'hCAFE_F00D);
         ck($sformatf("r36_be_c%0d", c), d_be, 4'hF);
         ck($sformatf("r36_h0wait_c%0d", c), h_wait[0], 1'b1);
         adv();
      end
      h_wr = '0; h_rd = 3'b101; d_wait = 1'b0;
      chk(); ck("r36_gap_idle", h_wait, 3'b111); adv();
      chk(); ck("r36_ptr1_host2_wins", h_wait, 3'b011); adv();
      h_rd = '0;
      chk(); adv();

      // Host 0 abandons mid-grant, then wins again.
      do_reset();
      h_rd = 3'b001; d_wait = 1'b1;
      chk(); adv();
      chk(); ck("r37_granted_read", d_rd, 1'b1); adv();
      h_rd = '0;
      chk(); ck("r37_abandon_read", d_rd, 1'b0); adv();
      h_rd = 3'b011; d_wait = 1'b0;
      chk(); ck("r37_idle_after", h_wait, 3'b111); adv();
      chk(); ck("r37_same_host", h_wait, 3'b110); adv();
      h_rd = '0;

      // Reset pulsed while host 1 is stalled.
      do_reset();
      h_rd = 3'b010; d_wait = 1'b1;
      chk(); adv();
      chk(); ck("r38_granted_read", d_rd, 1'b1);
      rst = 1'b1; adv(); rst = 1'b0;
      h_rd = 3'b011; d_wait = 1'b0;
      chk(); ck("r38_read_after_rst", d_rd, 1'b0); adv();
      chk(); ck("r38_host0_wins", h_wait, 3'b110); adv();
      h_rd = '0;

`ifdef AVN_ARB_TIMEOUT_EN
      // Device stuck busy: one-cycle timeout after TO stalls, then host 1.
      do_reset();
      h_rd = 3'b011; d_wait = 1'b1; d_rdata = 32'hFFFF_FFFF;
      chk(); adv();
      for (int c = 1; c <= TO; c++) begin
         chk();
         ck($sformatf("to_stall_c%0d", c), arb_to, 1'b0);
         ck($sformatf("to_read_c%0d", c), d_rd, 1'b1);
         adv();
      end
      chk();
      ck("to_pulse", arb_to, 1'b1);
      ck("to_h0wait", h_wait[0], 1'b0);
      ck("to_h0rdata", h_rdata[0], 32'h0);
      ck("to_dev_read", d_rd, 1'b0);
      adv();
      chk(); ck("to_pulse_end", arb_to, 1'b0); ck("to_idle", h_wait, 3'b111); adv();
      d_wait = 1'b0;
      chk(); ck("to_next_host1", h_wait, 3'b101); adv();
      h_rd = '0;
`endif

      // Random traffic with sticky requests and occasional reset.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom % 60 == 0);
         for (int i = 0; i < NH; i++) begin
            if ($urandom % 4 == 0) h_rd[i] = ~h_rd[i];
            if ($urandom % 8 == 0) h_wr[i] = ~h_wr[i];
            h_addr[i] = $urandom;
            h_be[i]   = 4'($urandom);
            h_wd[i]   = $urandom;
         end
         d_wait  = ($urandom % 3 != 0);
         d_rdata = $urandom;
         chk();
         adv();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
